// File: rtl/decode_stage.sv
// RV32I ID stage: register-file addressing, decode, load-use stall and ID/EX register.
// Bubbles (flush, hazard, no instruction, optionally illegal) load an all-zero ID/EX entry.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic            flush,
  input  logic            ex_hz_mem_read,
  input  logic [4:0]      ex_hz_rd,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_d1,
  input  logic [XLEN-1:0] rf_d2,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_alu_src_imm,
  output logic            ex_illegal
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, rs1_val, rs2_val;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal;
  } idex_t;

  idex_t idex_d, idex_q;

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic            wb, use1, use2, mrd, mwr, br, jmp, src_imm, ill, hz;
  logic [XLEN-1:0] imm;

  assign opc   = id_instr[6:0];
  assign rs1   = id_instr[19:15];
  assign rs2   = id_instr[24:20];
  assign rf_a1 = rs1;
  assign rf_a2 = rs2;

  always_comb begin
    wb = 1'b0; use1 = 1'b0; use2 = 1'b0; mrd = 1'b0; mwr = 1'b0;
    br = 1'b0; jmp = 1'b0; src_imm = 1'b1; ill = 1'b0; imm = '0;
    unique case (opc)
      7'b0110111,
      7'b0010111: begin wb = 1'b1; imm = {id_instr[31:12], 12'b0}; end
      7'b1101111: begin
        wb = 1'b1; jmp = 1'b1;
        imm = {{12{id_instr[31]}}, id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
      end
      7'b1100111: begin
        wb = 1'b1; jmp = 1'b1; use1 = 1'b1;
        imm = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      7'b1100011: begin
        br = 1'b1; use1 = 1'b1; use2 = 1'b1; src_imm = 1'b0;
        imm = {{20{id_instr[31]}}, id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
      end
      7'b0000011: begin
        mrd = 1'b1; wb = 1'b1; use1 = 1'b1;
        imm = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      7'b0100011: begin
        mwr = 1'b1; use1 = 1'b1; use2 = 1'b1;
        imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      end
      7'b0010011: begin
        wb = 1'b1; use1 = 1'b1;
        imm = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      7'b0110011: begin wb = 1'b1; use1 = 1'b1; use2 = 1'b1; src_imm = 1'b0; end
      default:    begin ill = 1'b1; src_imm = 1'b0; end
    endcase
  end

  // Stores and branches write nothing; zeroing rd keeps forwarding/hazard logic quiet.
  assign rd = (mwr || br || ill) ? 5'd0 : id_instr[11:7];

  assign hz = id_valid && ex_hz_mem_read && (ex_hz_rd != 5'd0) &&
              ((use1 && rs1 == ex_hz_rd) || (use2 && rs2 == ex_hz_rd));
  assign stall = hz && !flush && !rst;

  always_comb begin
    idex_d = '0;
    if (!flush && !hz && id_valid) begin
      if (!ill) begin
        idex_d.valid       = 1'b1;
        idex_d.pc          = id_pc;
        idex_d.rs1_val     = rf_d1;
        idex_d.rs2_val     = rf_d2;
        idex_d.rs1         = use1 ? rs1 : 5'd0;
        idex_d.rs2         = use2 ? rs2 : 5'd0;
        idex_d.rd          = rd;
        idex_d.imm         = imm;
        idex_d.funct3      = id_instr[14:12];
        idex_d.funct7b5    = id_instr[30];
        idex_d.reg_write   = wb && (rd != 5'd0);
        idex_d.mem_read    = mrd;
        idex_d.mem_write   = mwr;
        idex_d.branch      = br;
        idex_d.jump        = jmp;
        idex_d.alu_src_imm = src_imm;
      end else if (NOP_ON_ILLEGAL) begin
        // Carry the PC so EX can raise a precise illegal-instruction trap.
        idex_d.valid   = 1'b1;
        idex_d.pc      = id_pc;
        idex_d.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign ex_valid       = idex_q.valid;
  assign ex_pc          = idex_q.pc;
  assign ex_rs1_val     = idex_q.rs1_val;
  assign ex_rs2_val     = idex_q.rs2_val;
  assign ex_rs1         = idex_q.rs1;
  assign ex_rs2         = idex_q.rs2;
  assign ex_rd          = idex_q.rd;
  assign ex_imm         = idex_q.imm;
  assign ex_funct3      = idex_q.funct3;
  assign ex_funct7b5    = idex_q.funct7b5;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_branch      = idex_q.branch;
  assign ex_jump        = idex_q.jump;
  assign ex_alu_src_imm = idex_q.alu_src_imm;
  assign ex_illegal     = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; a second instance covers illegal-as-bubble.
module tb_decode_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        id_valid = 1'b0, flush = 1'b0, hz_mr = 1'b0;
  logic [31:0] instr = '0, pc = '0, d1 = '0, d2 = '0;
  logic [4:0]  hz_rd = '0;

  logic [4:0]  a1, a2, rs1, rs2, rd;
  logic        stall, v, f7, rw, mr, mw, br, jp, si, il;
  logic [31:0] epc, v1, v2, imm;
  logic [2:0]  f3;

  logic [4:0]  b_a1, b_a2, b_rs1, b_rs2, b_rd;
  logic        b_stall, b_v, b_f7, b_rw, b_mr, b_mw, b_br, b_jp, b_si, b_il;
  logic [31:0] b_pc, b_v1, b_v2, b_imm;
  logic [2:0]  b_f3;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  decode_stage #(.NOP_ON_ILLEGAL(1'b1)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(instr), .id_pc(pc),
    .flush(flush), .ex_hz_mem_read(hz_mr), .ex_hz_rd(hz_rd),
    .rf_a1(a1), .rf_a2(a2), .rf_d1(d1), .rf_d2(d2), .stall(stall),
    .ex_valid(v), .ex_pc(epc), .ex_rs1_val(v1), .ex_rs2_val(v2),
    .ex_rs1(rs1), .ex_rs2(rs2), .ex_rd(rd), .ex_imm(imm), .ex_funct3(f3),
    .ex_funct7b5(f7), .ex_reg_write(rw), .ex_mem_read(mr), .ex_mem_write(mw),
    .ex_branch(br), .ex_jump(jp), .ex_alu_src_imm(si), .ex_illegal(il));

  decode_stage #(.NOP_ON_ILLEGAL(1'b0)) u_bub (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(instr), .id_pc(pc),
    .flush(flush), .ex_hz_mem_read(hz_mr), .ex_hz_rd(hz_rd),
    .rf_a1(b_a1), .rf_a2(b_a2), .rf_d1(d1), .rf_d2(d2), .stall(b_stall),
    .ex_valid(b_v), .ex_pc(b_pc), .ex_rs1_val(b_v1), .ex_rs2_val(b_v2),
    .ex_rs1(b_rs1), .ex_rs2(b_rs2), .ex_rd(b_rd), .ex_imm(b_imm), .ex_funct3(b_f3),
    .ex_funct7b5(b_f7), .ex_reg_write(b_rw), .ex_mem_read(b_mr), .ex_mem_write(b_mw),
    .ex_branch(b_br), .ex_jump(b_jp), .ex_alu_src_imm(b_si), .ex_illegal(b_il));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an instruction at the falling edge so it is stable well before the next rising edge.
  task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] p);
    @(negedge clk);
    id_valid = vld; instr = ins; pc = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'd0, v}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // ADDI x5,x1,-3
    d1 = 32'd10; d2 = 32'd77;
    drive(1'b1, 32'hFFD08293, 32'h100);
    chk("addi_rf_a1", {27'd0, a1}, 32'd1);
    chk("addi_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("addi_valid", {31'd0, v}, 32'd1);
    chk("addi_rd", {27'd0, rd}, 32'd5);
    chk("addi_rs1", {27'd0, rs1}, 32'd1);
    chk("addi_rs2", {27'd0, rs2}, 32'd0);
    chk("addi_imm", imm, 32'hFFFFFFFD);
    chk("addi_rs1_val", v1, 32'd10);
    chk("addi_pc", epc, 32'h100);
    chk("addi_rw", {31'd0, rw}, 32'd1);
    chk("addi_src_imm", {31'd0, si}, 32'd1);

    // Load-use on ADD x3,x2,x4 against a load writing x2
    hz_mr = 1'b1; hz_rd = 5'd2;
    drive(1'b1, 32'h004101B3, 32'h104);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {31'd0, v}, 32'd0);
    chk("lu_bubble_rw", {31'd0, rw}, 32'd0);
    @(negedge clk); hz_mr = 1'b0; #1;
    chk("lu_release", {31'd0, stall}, 32'd0);
    tick();
    chk("add_valid", {31'd0, v}, 32'd1);
    chk("add_rs1", {27'd0, rs1}, 32'd2);
    chk("add_rs2", {27'd0, rs2}, 32'd4);
    chk("add_rd", {27'd0, rd}, 32'd3);
    chk("add_src_imm", {31'd0, si}, 32'd0);
    chk("add_imm", imm, 32'd0);

    // Hazard and flush together: bubble, no stall
    hz_mr = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h004101B3, 32'h108);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_valid", {31'd0, v}, 32'd0);
    flush = 1'b0;

    // SW x2,-4(x1): rs2 matches the load
    drive(1'b1, 32'hFE20AE23, 32'h10C);
    chk("sw_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); hz_mr = 1'b0; #1;
    tick();
    chk("sw_valid", {31'd0, v}, 32'd1);
    chk("sw_imm", imm, 32'hFFFFFFFC);
    chk("sw_mw", {31'd0, mw}, 32'd1);
    chk("sw_rd", {27'd0, rd}, 32'd0);
    chk("sw_rw", {31'd0, rw}, 32'd0);
    chk("sw_rs2", {27'd0, rs2}, 32'd2);

    // JAL x1 whose bits[19:15] equal the load rd: no source use, no stall
    hz_mr = 1'b1; hz_rd = 5'd2;
    drive(1'b1, 32'h000100EF, 32'h110);
    chk("jal_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("jal_jump", {31'd0, jp}, 32'd1);
    chk("jal_imm", imm, 32'h00010000);
    chk("jal_rd", {27'd0, rd}, 32'd1);
    chk("jal_rs1", {27'd0, rs1}, 32'd0);
    hz_mr = 1'b0;

    // BEQ x1,x2,-8
    drive(1'b1, 32'hFE208CE3, 32'h114);
    tick();
    chk("beq_imm", imm, 32'hFFFFFFF8);
    chk("beq_branch", {31'd0, br}, 32'd1);
    chk("beq_rd", {27'd0, rd}, 32'd0);
    chk("beq_rw", {31'd0, rw}, 32'd0);
    chk("beq_src_imm", {31'd0, si}, 32'd0);

    // ADDI x0,x0,0
    drive(1'b1, 32'h00000013, 32'h118);
    tick();
    chk("nop_valid", {31'd0, v}, 32'd1);
    chk("nop_rw", {31'd0, rw}, 32'd0);

    // LUI x7,0x12345
    drive(1'b1, 32'h123453B7, 32'h11C);
    tick();
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rs1", {27'd0, rs1}, 32'd0);
    chk("lui_rd", {27'd0, rd}, 32'd7);
    chk("lui_rw", {31'd0, rw}, 32'd1);

    // Illegal opcode 0x7F on both instances
    drive(1'b1, 32'h0000007F, 32'h120);
    tick();
    chk("ill_valid", {31'd0, v}, 32'd1);
    chk("ill_flag", {31'd0, il}, 32'd1);
    chk("ill_ctrl", {26'd0, rw, mr, mw, br, jp, si}, 32'd0);
    chk("ill_rd", {27'd0, rd}, 32'd0);
    chk("ill_bub_valid", {31'd0, b_v}, 32'd0);

    drive(1'b0, 32'h00000013, 32'h124);
    tick();
    chk("novalid", {31'd0, v}, 32'd0);

    // LW x6,8(x5)
    drive(1'b1, 32'h0082A303, 32'h128);
    tick();
    chk("lw_mr", {31'd0, mr}, 32'd1);
    chk("lw_rw", {31'd0, rw}, 32'd1);
    chk("lw_imm", imm, 32'd8);
    chk("lw_rs1", {27'd0, rs1}, 32'd5);
    chk("lw_rs2", {27'd0, rs2}, 32'd0);
    chk("lw_bub_valid", {31'd0, b_v}, 32'd1);

    // Asynchronous reset mid-cycle while a hazard is pending
    hz_mr = 1'b1; hz_rd = 5'd2;
    drive(1'b1, 32'h004101B3, 32'h12C);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, v}, 32'd0);
    chk("arst_ctrl", {26'd0, rw, mr, mw, br, jp, si}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("rst_hold_valid", {31'd0, v}, 32'd0);
    @(negedge clk); rst = 1'b0; hz_mr = 1'b0; #1;
    tick();
    chk("post_rst_valid", {31'd0, v}, 32'd1);
    chk("post_rst_pc", epc, 32'h12C);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline, sitting between the IF/ID register and execute.
- Drives the register-file read addresses combinationally from the fetched instruction and decodes opcode/immediate/control.
- Captures register-file read data plus decoded fields into the ID/EX pipeline register.
- Detects load-use hazards and raises a stall to fetch; accepts a flush from branch/jump resolution.

Parameters:
XLEN, 32, datapath width (only 32 supported)
NOP_ON_ILLEGAL, 1, 1: illegal opcode issues ex_valid=1 with all side-effect controls 0 and ex_illegal=1; 0: illegal opcode becomes a bubble (ex_valid=0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  IF/ID holds a valid instruction
id_instr  in  32  instruction word
id_pc  in  32  instruction PC
flush  in  1  kill the instruction in ID (taken branch/jump from EX)
ex_hz_mem_read  in  1  instruction currently in EX is a load
ex_hz_rd  in  5  rd of instruction currently in EX
rf_a1  out  5  register-file read address 1
rf_a2  out  5  register-file read address 2
rf_d1  in  32  register-file read data 1
rf_d2  in  32  register-file read data 2
stall  out  1  hold PC and IF/ID this cycle
ex_valid, ex_pc[32], ex_rs1_val[32], ex_rs2_val[32], ex_rs1[5], ex_rs2[5], ex_rd[5], ex_imm[32], ex_funct3[3], ex_funct7b5[1]  out  ID/EX payload
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src_imm, ex_illegal  out  1 each  ID/EX control

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: all ex_* registers clear to 0 immediately on rst assertion, regardless of clk. stall is combinational and 0 while rst=1.
- rf_a1 = id_instr[19:15]; rf_a2 = id_instr[24:20]. These are driven combinationally and always, independent of id_valid. The register file returns 0 for x0 and bypasses same-cycle writeback, so rf_d1/rf_d2 are captured as-is.
- Decode on opcode id_instr[6:0]:
  - LUI 0110111: U-imm, wb
  - AUIPC 0010111: U-imm, wb
  - JAL 1101111: J-imm, jump, wb
  - JALR 1100111: I-imm, jump, wb, uses rs1
  - BRANCH 1100011: B-imm, branch, uses rs1 and rs2
  - LOAD 0000011: I-imm, mem_read, wb, uses rs1
  - STORE 0100011: S-imm, mem_write, uses rs1 and rs2
  - OP-IMM 0010011: I-imm, wb, uses rs1
  - OP 0110011: imm=0, wb, uses rs1 and rs2
  - Anything else is illegal.
- Immediates are sign-extended to 32 bits. B- and J-imm have bit0=0. U-imm = {instr[31:12], 12'b0}.
- ex_alu_src_imm=1 for all formats except OP, BRANCH and illegal.
- ex_rs1 and ex_rs2 are registered as 0 when that source is unused, so no false forwarding occurs downstream.
- ex_rd = 0 for STORE, BRANCH and illegal. ex_reg_write = wb AND (rd != 0).
- Load-use hazard: hz = id_valid AND ex_hz_mem_read AND ex_hz_rd != 0 AND ((uses_rs1 AND rs1 == ex_hz_rd) OR (uses_rs2 AND rs2 == ex_hz_rd)).
- stall = hz AND NOT flush. Combinational, same cycle as the hazard.
- Each rising edge, first match wins:
  1. flush=1 → bubble
  2. hz=1 → bubble (IF/ID is held by stall, so the instruction is re-decoded next cycle)
  3. id_valid=0 → bubble
  4. illegal → per NOP_ON_ILLEGAL
  5. otherwise → capture the full payload, ex_valid=1
- Bubble: ex_valid=0 and all control outputs 0. Payload fields (pc, values, imm) are don't-care but are driven to 0.
- A load-use hazard stalls exactly one cycle. The next cycle, EX holds the bubble (ex_hz_mem_read=0), so hz drops.
- Flush during a hazard: the bubble is inserted and stall=0, so fetch redirects.
- Latency: ID → ID/EX is 1 cycle. There is no internal state beyond the ID/EX register.
- Reset asserted mid-stream: all in-flight ID/EX content is discarded. The first capture happens on the first rising edge after rst deasserts.

Test Plan:
- Reset: assert rst asynchronously between edges with ex_valid=1 → all ex_* read 0 before the next edge; stall=0.
- ADDI x5,x1,-3 (0xFFD08293), id_valid=1, rf_d1=10 → rf_a1=1. Next cycle: ex_valid=1, ex_rd=5, ex_rs1=1, ex_rs2=0, ex_imm=0xFFFFFFFD, ex_rs1_val=10, ex_reg_write=1, ex_alu_src_imm=1.
- Load-use: ex_hz_mem_read=1, ex_hz_rd=2, ID holds ADD x3,x2,x4 → stall=1, next ex_valid=0. Drop ex_hz_mem_read next cycle → stall=0, ADD captured with ex_rs1=2, ex_rs2=4.
- Hazard plus flush in the same cycle → stall=0, ex_valid=0. Separately, a STORE whose rs2 matches a load rd → stall=1, while a JAL with bits[19:15]==ex_hz_rd → stall=0.
- BEQ x1,x2,-8 (0xFE208CE3) → ex_imm=0xFFFFFFF8, ex_branch=1, ex_rd=0, ex_reg_write=0. Also ADDI x0,x0,0 → ex_reg_write=0.
- Opcode 0x7F with NOP_ON_ILLEGAL=1 → ex_valid=1, ex_illegal=1, all other controls 0. With NOP_ON_ILLEGAL=0 → ex_valid=0.
